// File: rtl/cnt_sched_pkg.sv
// rtl/cnt_sched_pkg.sv - shared types and round-robin pick for the counter scheduler
package cnt_sched_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request at or above ptr, wrapping at n; requests at index >= n are ignored.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 n);
    pick_t p;
    int    j;
    p.valid = 1'b0;
    p.idx   = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n && !p.valid && req[j[IDX_W-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = j[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/cnt_core.sv
// rtl/cnt_core.sv - loadable interval counter with terminal-count compare
module cnt_core #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_len <= '0;
    end else begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_load) begin
        r_len <= i_load_val;
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == r_len);

endmodule

// File: rtl/cnt_sched.sv
// rtl/cnt_sched.sv - round-robin arbiter that lends one interval counter to N_REQ clients
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int N_REQ = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*CNT_W-1:0] i_len,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_done,
  output logic [CNT_W-1:0]       o_cnt,
  output logic                   o_cout,
  output logic                   o_busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_idx_inc;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [N_REQ-1:0] r_done;
  logic [N_REQ-1:0] w_done_nxt;
  logic [MAX_REQ-1:0] w_req_ext;
  logic             w_req_k;
  logic             w_clr;
  logic             w_en;
  logic             w_load;
  logic             w_tc;
  logic [CNT_W-1:0] w_len_sel;
  logic [CNT_W-1:0] w_cnt;
  pick_t            w_pick;

  assign w_req_ext = MAX_REQ'(i_req);
  assign w_req_k   = w_req_ext[r_idx];
  assign w_pick    = rr_pick(w_req_ext, r_ptr, N_REQ);
  assign w_idx_inc = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_len_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_pick.idx == IDX_W'(k)) begin
        w_len_sel = i_len[k*CNT_W +: CNT_W];
      end
    end
  end

  cnt_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (w_clr),
    .i_en       (w_en),
    .i_load     (w_load),
    .i_load_val (w_len_sel),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  // Withdrawal outranks terminal count so a dropped request never yields a done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick.valid) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = w_pick.idx;
          w_gnt_nxt   = N_REQ'(1) << w_pick.idx;
          w_load      = 1'b1;
          w_clr       = 1'b1;
        end
      end
      S_RUN: begin
        if (!w_req_k) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_clr       = 1'b1;
          w_ptr_nxt   = w_idx_inc;
        end else if (w_tc) begin
          w_state_nxt = S_DONE;
          w_gnt_nxt   = '0;
          w_done_nxt  = N_REQ'(1) << r_idx;
        end else begin
          w_en        = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_clr       = 1'b1;
        w_ptr_nxt   = w_idx_inc;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_clr       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_gnt  = r_gnt;
  assign o_done = r_done;
  assign o_cnt  = w_cnt;
  assign o_cout = (r_state == S_RUN) && w_tc && w_req_k;
  assign o_busy = (r_state != S_IDLE);

endmodule

// File: doc/cnt_sched.md
# cnt_sched

Round-robin scheduler that shares one CNT_W-bit interval counter between N_REQ requesters. Each requester asks for a timed interval of a programmed length. The scheduler grants the counter to one requester at a time, runs it from 0 up to that length, and reports completion with a one-cycle done pulse. It sits between client blocks and the free-running counter datapath, and turns that datapath into an arbitrated, loadable timer resource.

## Interface
Parameters:
- CNT_W, 4, counter width; the terminal value is a CNT_W-bit length.
- N_REQ, 4, number of requesters (2..8).

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  N_REQ  per-requester request level; held high until the matching o_done pulse.
- i_len  in  N_REQ*CNT_W  packed lengths; requester k uses bits [k*CNT_W +: CNT_W]. Sampled only at grant.
- o_gnt  out  N_REQ  one-hot grant; all zero when idle.
- o_done  out  N_REQ  one-cycle completion pulse, one-hot.
- o_cnt  out  CNT_W  current count of the shared counter.
- o_cout  out  1  high in the cycle where o_cnt equals the latched length while running.
- o_busy  out  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - If any i_req bit is high, choose the first requester at or above the pointer, searching upward with wrap.
  - Latch its i_len and set cnt=0.
  - Assert o_gnt[k] and go to RUN.
  - Otherwise stay in IDLE.
- RUN, no early withdrawal:
  - If cnt == latched length, assert o_cout and go to DONE. cnt holds.
  - Otherwise cnt increments by 1.
  - RUN therefore lasts len+1 cycles.
- RUN, early withdrawal: if i_req[k] goes low in RUN, take these actions at the next edge:
  - go to IDLE and clear o_gnt and cnt;
  - suppress o_done;
  - advance the pointer to k+1 mod N_REQ.
  - o_cout is masked in that cycle.
- DONE:
  - o_done[k]=1 and o_gnt=0.
  - Pointer becomes k+1 mod N_REQ; cnt clears to 0; go to IDLE.
- Requests for other requesters that arrive during RUN or DONE wait; nothing preempts a running grant.
- If i_req[k] is still high in IDLE after done, it counts as a new request and competes by round-robin.
- Width rules:
  - cnt never exceeds the latched length, so it never wraps. len = 2^CNT_W−1 is legal.
  - len=0 gives a single RUN cycle with o_cout high and o_cnt=0.
- i_len changes after grant have no effect.

## Timing
- Reset values:
  - state=IDLE, pointer=0, latched length=0.
  - o_gnt=0, o_done=0, o_cnt=0, o_cout=0, o_busy=0.
- Reset takes effect immediately, asynchronously. It aborts any interval with no done pulse.
- Latency for requester k with length L: request seen in IDLE at edge e; o_gnt high from e+1; o_cnt shows 0..L over the following L+1 cycles; o_done in the next cycle.
  - Total edge count from the edge that samples the request to the done pulse: L+2.
  - Back-to-back grants have one IDLE cycle between them.
- All outputs are registered, except o_cout and o_busy, which decode from registered state and cnt.

## Structure
- Package cnt_sched_pkg holds the state encoding localparams (S_IDLE, S_RUN, S_DONE) and the round-robin pick function (request vector, pointer → index, valid).
- Sub-module cnt_core: CNT_W counter with synchronous clear, enable, and terminal compare against a loaded value; outputs cnt and tc. It is instantiated once, and the scheduler drives clear, enable and load.

## Test plan
- Reset check: i_reset high for 3 cycles mid-run at cnt=5 → all outputs 0 immediately (asynchronous); after release with no requests, still IDLE.
- Single request, i_req=4'b0001, len0=3 → o_gnt=0001 one cycle after sampling; o_cnt sequence 0,1,2,3; o_cout with cnt=3; o_done=0001 on the 5th edge after sampling; o_busy low again the cycle after.
- Fairness: i_req=4'b1111, all lengths 1 → grant order 0,1,2,3,0 with one done each; each full grant-to-grant cycle takes 4 cycles.
- Length boundaries: len=0 → one RUN cycle with o_cout=1 and o_cnt=0. len=15 → o_cnt reaches 15, no wrap, done follows.
- Withdrawal: requester 1 with len=6 drops i_req at cnt=2 → next cycle IDLE, o_cnt=0, no o_done. A pending requester 2 is granted next.
- Late length change: i_len changes during RUN → the interval still ends at the length latched at grant.
